grid_render_scan: RTL and testbench

GRID_RENDER_SCAN -- requirements
Module: grid_render_scan

---
 rtl/grid_render_pkg.sv | 16 +
 rtl/cell_pixel_walker.sv | 27 ++
 rtl/grid_render_scan.sv | 95 +++++++++
 tb/tb_grid_render_scan.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/grid_render_pkg.sv
// grid_render_pkg: shared FSM states, default grid geometry and a width helper.
// No ports; imported by grid_render_scan and cell_pixel_walker.
package grid_render_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, FIN} state_t;
  localparam int DEF_ROWS = 20;
  localparam int DEF_COLS = 10;
  localparam int DEF_CELL = 24;
  localparam int DEF_GAP  = 1;
  localparam int DEF_X0   = 200;
  localparam int DEF_Y0   = 0;
  localparam int DEF_CW   = 3;
  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int wbits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cell_pixel_walker.sv
// cell_pixel_walker: scans px,py over 0..SQ-1 with px fastest.
// Ports: clk, reset (sync, active-high); load clears both counters;
// advance steps one pixel; px, py current offsets; last flags (SQ-1,SQ-1).
module cell_pixel_walker import grid_render_pkg::*; #(
  parameter int SQ = DEF_CELL - DEF_GAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  output logic [wbits(SQ)-1:0]  px,
  output logic [wbits(SQ)-1:0]  py,
  output logic                  last
);
  localparam int PW = wbits(SQ);
  localparam logic [PW-1:0] MAX = PW'(SQ - 1);
  assign last = (px == MAX) && (py == MAX);
  always_ff @(posedge clk) begin
    if (reset || load) begin
      px <= '0;
      py <= '0;
    end else if (advance) begin
      px <= (px == MAX) ? '0 : px + 1'b1;
      py <= (px != MAX) ? py : (py == MAX) ? '0 : py + 1'b1;
    end
  end
endmodule

// File: rtl/grid_render_scan.sv
// grid_render_scan: walks a ROWS x COLS grid, fetches each cell code from an
// external one-cycle-latency memory and emits the cell's SQ x SQ pixel square.
// Ports: clk, reset (sync, active-high); start/skip_empty request a render;
// cell_addr/cell_data memory read port; x, y, color, pix_valid/pix_ready pixel
// stream; busy while rendering; done pulses once after the last pixel.
module grid_render_scan import grid_render_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int CELL = DEF_CELL,
  parameter int GAP  = DEF_GAP,
  parameter int X0   = DEF_X0,
  parameter int Y0   = DEF_Y0,
  parameter int CW   = DEF_CW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          skip_empty,
  output logic [wbits(ROWS*COLS)-1:0]   cell_addr,
  input  logic [CW-1:0]                 cell_data,
  output logic [10:0]                   x,
  output logic [10:0]                   y,
  output logic [CW-1:0]                 color,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          busy,
  output logic                          done
);
  localparam int SQ  = CELL - GAP;
  localparam int RW  = wbits(ROWS);
  localparam int CLW = wbits(COLS);
  localparam int PW  = wbits(SQ);
  state_t state, nxt;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic [PW-1:0]  px, py;
  logic [CW-1:0]  color_q;
  logic           skip_q, last, xfer, empty, final_cell, step;
  assign xfer       = (state == DRAW) && pix_ready;
  assign empty      = skip_q && (cell_data == '0);
  assign final_cell = (row == RW'(ROWS - 1)) && (col == CLW'(COLS - 1));
  assign step       = ((state == WAIT) && empty) || (xfer && last);
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = WAIT;
      WAIT:    nxt = empty ? (final_cell ? FIN : FETCH) : DRAW;
      DRAW:    nxt = (xfer && last) ? (final_cell ? FIN : FETCH) : DRAW;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // cell_addr tracks row*COLS+col incrementally; it changes only on entry to
  // FETCH, so the memory word is valid throughout the following WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      cell_addr <= '0;
      skip_q    <= 1'b0;
      color_q   <= '0;
    end else begin
      if (state == IDLE && start) begin
        row       <= '0;
        col       <= '0;
        cell_addr <= '0;
        skip_q    <= skip_empty;
      end
      if (state == WAIT) color_q <= cell_data;
      if (step && !final_cell) begin
        col       <= (col == CLW'(COLS - 1)) ? '0 : col + 1'b1;
        row       <= (col == CLW'(COLS - 1)) ? row + 1'b1 : row;
        cell_addr <= cell_addr + 1'b1;
      end
    end
  end
  cell_pixel_walker #(.SQ(SQ)) walker (
    .clk     (clk),
    .reset   (reset),
    .load    (state == WAIT),
    .advance (xfer),
    .px      (px),
    .py      (py),
    .last    (last)
  );
  // Pixel outputs are forced to zero outside DRAW so idle/reset values are 0.
  assign pix_valid = (state == DRAW);
  assign busy      = (state == FETCH) || (state == WAIT) || (state == DRAW);
  assign done      = (state == FIN);
  assign color     = pix_valid ? color_q : '0;
  assign x         = pix_valid ? 11'(X0 + int'(col) * CELL + GAP + int'(px)) : '0;
  assign y         = pix_valid ? 11'(Y0 + int'(row) * CELL + GAP + int'(py)) : '0;
endmodule

// File: tb/tb_grid_render_scan.sv
// tb_grid_render_scan: scoreboard bench for grid_render_scan on a small grid.
module tb_grid_render_scan;
  localparam int ROWS = 4, COLS = 3, CELL = 8, GAP = 1, X0 = 200, Y0 = 10, CW = 3;
  localparam int SQ = CELL - GAP, N = ROWS * COLS;
  logic clk = 0, reset = 1, start = 0, skip_empty = 0, pix_ready = 1;
  logic pix_valid, busy, done;
  logic [3:0] cell_addr;
  logic [CW-1:0] cell_data = '0, color;
  logic [10:0] x, y;
  logic [CW-1:0] mem [N];
  int n_checks = 0, n_fail = 0, cyc = 0, c0 = 0, done_cyc = 0, done_cnt = 0;
  int npix = 0, exp_cycles = 0, exp_npix = 0, rdy_mode = 0;
  bit mon_en = 0, prev_stall = 0;
  logic [24:0] prev_xyc, exp_xyc;
  logic [24:0] q[$];

  always #5 clk = ~clk;

  grid_render_scan #(.ROWS(ROWS), .COLS(COLS), .CELL(CELL), .GAP(GAP),
                     .X0(X0), .Y0(Y0), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .skip_empty(skip_empty),
    .cell_addr(cell_addr), .cell_data(cell_data), .x(x), .y(y), .color(color),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .done(done));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    cell_data <= mem[cell_addr];
  end

  always @(posedge clk) begin
    #1;
    pix_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~pix_ready : 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_xyc", {x, y, color}, prev_xyc);
        check("hold_valid", pix_valid, 1);
      end
      if (pix_valid) check("busy_draw", busy, 1);
      if (pix_valid && pix_ready) begin
        exp_xyc = (q.size() > 0) ? q.pop_front() : 25'h1ffffff;
        check("pixel", {x, y, color}, exp_xyc);
        npix++;
      end
      if (done) begin
        check("busy_in_fin", busy, 0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_xyc = {x, y, color};
    end
  end

  task automatic expect_render(input bit skip);
    logic [CW-1:0] code;
    q.delete();
    exp_cycles = 1;
    exp_npix = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        code = mem[r * COLS + c];
        if (skip && code == 0) exp_cycles += 2;
        else begin
          exp_cycles += 2 + SQ * SQ;
          for (int py = 0; py < SQ; py++)
            for (int px = 0; px < SQ; px++) begin
              q.push_back({11'(X0 + c * CELL + GAP + px), 11'(Y0 + r * CELL + GAP + py), code});
              exp_npix++;
            end
        end
      end
  endtask

  task automatic do_start(input bit skip);
    expect_render(skip);
    @(posedge clk); #1;
    skip_empty = skip;
    start = 1;
    c0 = cyc;
    done_cnt = 0;
    npix = 0;
    mon_en = 1;
    @(posedge clk); #1;
    start = 0;
    skip_empty = ~skip;
  endtask

  task automatic wait_done(input bit chk_cyc, input bit fin_start);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    if (fin_start && done_cnt > 0) begin
      start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    repeat (6) @(negedge clk);
    if (chk_cyc) check("done_cycle", done_cyc - c0, exp_cycles);
    check("done_pulses", done_cnt, 1);
    check("pix_count", npix, exp_npix);
    check("sb_left", q.size(), 0);
    check("busy_after", busy, 0);
    check("valid_after", pix_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    start = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    check("rst_addr", cell_addr, 0);
    @(posedge clk); #1;
    reset = 0;
    start = 0;
    repeat (3) @(negedge clk);
    check("start_with_reset_busy", busy, 0);
    check("start_with_reset_valid", pix_valid, 0);
    // full grid, zero codes still drawn
    for (int i = 0; i < N; i++) mem[i] = 3'(i);
    do_start(0);
    wait_done(1, 0);
    // only the last cell lit, empty cells skipped
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[N-1] = 3;
    do_start(1);
    wait_done(1, 0);
    // all cells empty and skipped: no pixels
    mem[N-1] = 0;
    do_start(1);
    wait_done(1, 0);
    // random codes, ready toggling, start mid-render and in FIN
    for (int i = 0; i < N; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[0] = 0;
    mem[5] = 0;
    rdy_mode = 1;
    do_start(1);
    repeat (60) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(0, 1);
    // random ready, no skipping
    rdy_mode = 2;
    do_start(0);
    wait_done(0, 0);
    // reset mid-draw abandons the render; restart begins from cell 0
    rdy_mode = 0;
    for (int i = 0; i < N; i++) mem[i] = 5;
    do_start(0);
    for (int i = 0; i < 500 && npix < 20; i++) begin
      @(posedge clk); #1;
    end
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", pix_valid, 0);
    check("rst_mid_busy", busy, 0);
    @(posedge clk); #1;
    reset = 0;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt, 0);
    check("idle_after_reset", busy, 0);
    do_start(0);
    wait_done(1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
